// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-in / parallel-out receiver. A frame begins with a `start` strobe;
// after that, every cycle with `sen`=1 samples one bit of `sin`, LSB first.
// When the last data bit arrives, the word is presented on `Q` with `valid`
// set. The word stays held until the consumer pulses `ack`.
//
// Optional feature macro: SIPO_PARITY_EN
//   undefined : frames are N data bits, the PAR state is absent, perr = 0.
//   defined   : each frame carries one extra even-parity bit after the N data
//               bits. perr reports a parity error for the word in Q.
//
// Parameters
//   N        data word width in bits (N >= 2), default 8
//
// Ports
//   clock    in   rising-edge clock for all state
//   reset    in   synchronous, active-high reset (overrides every input)
//   start    in   frame-begin strobe; the first bit comes on a later sen cycle
//   sen      in   bit-valid strobe; sin is sampled when sen=1
//   sin      in   serial data, LSB first
//   ack      in   consumer acknowledge of the held word
//   Q        out  [N-1:0] received word, registered
//   valid    out  Q holds a complete, unacknowledged word
//   busy     out  a frame is being received (SHIFT or PAR)
//   overrun  out  sticky: start arrived while a word was still unacknowledged
//   perr     out  parity error for the word in Q (always 0 without parity)
// -----------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         sen,
  input  logic         sin,
  input  logic         ack,
  output logic [N-1:0] Q,
  output logic         valid,
  output logic         busy,
  output logic         overrun,
  output logic         perr
);

  // The counter must hold the values 0..N-1.
  localparam int            CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SIPO_PARITY_EN
    PAR   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

`ifdef SIPO_PARITY_EN
  // Even-parity check. The result is 1 when the N data bits plus the
  // parity bit hold an odd number of ones, which is an error.
  function automatic logic parity_error(input logic [N-1:0] data,
                                        input logic         pbit);
    return (^data) ^ pbit;
  endfunction
`endif

  state_t        state_q,   state_d;
  logic [N-1:0]  sreg_q,    sreg_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [N-1:0]  q_q,       q_d;
  logic          valid_q,   valid_d;
  logic          busy_q,    busy_d;
  logic          overrun_q, overrun_d;
  logic [N-1:0]  shifted_s;
`ifdef SIPO_PARITY_EN
  logic          perr_q,    perr_d;
`endif

  // Shift-right form: the new bit enters at the MSB. After N samples, the
  // first bit received has reached bit 0.
  always_comb begin
    shifted_s = {sin, sreg_q[N-1:1]};
  end

  // Next-state and datapath logic. Every register holds by default.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef SIPO_PARITY_EN
    perr_d    = perr_q;
`endif

    case (state_q)
      IDLE: begin
        // The start cycle itself takes no sample.
        if (start) begin
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (start) begin
          // A new start aborts the partial frame. This is not an overrun.
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end else if (sen) begin
          if (cnt_q == LAST) begin
            sreg_d = shifted_s;
            cnt_d  = '0;
`ifdef SIPO_PARITY_EN
            state_d = PAR;
`else
            // The final data bit goes straight into Q, so valid rises on
            // the same edge that samples the last bit.
            q_d     = shifted_s;
            valid_d = 1'b1;
            state_d = DONE;
`endif
          end else begin
            sreg_d = shifted_s;
            cnt_d  = cnt_q + CW'(1);
          end
        end else begin
          state_d = SHIFT;
        end
      end

`ifdef SIPO_PARITY_EN
      PAR: begin
        if (start) begin
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end else if (sen) begin
          // sreg_q already holds all N data bits. sin is the parity bit.
          q_d     = sreg_q;
          perr_d  = parity_error(sreg_q, sin);
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = PAR;
        end
      end
`endif

      DONE: begin
        if (ack) begin
          valid_d = 1'b0;
          if (start) begin
            // ack and start together: release the word and begin a new
            // frame at once.
            state_d = SHIFT;
            sreg_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          // The word is still unread. Flag the overrun, ignore the start,
          // and keep Q and valid unchanged.
          overrun_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // busy is taken from the next state so that the output stays registered.
`ifdef SIPO_PARITY_EN
    busy_d = (state_d == SHIFT) || (state_d == PAR);
`else
    busy_d = (state_d == SHIFT);
`endif
  end

  // State and output registers, with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SIPO_PARITY_EN
  // Parity-error register. It loads together with Q.
  always_ff @(posedge clock) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  // Drive the parity-error output.
  always_comb begin
    perr = perr_q;
  end
`else
  // With parity disabled, no parity error can occur.
  always_comb begin
    perr = 1'b0;
  end
`endif

  // Drive the output ports from their registers.
  always_comb begin
    Q       = q_q;
    valid   = valid_q;
    busy    = busy_q;
    overrun = overrun_q;
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//
// Directed testbench for sipo_deserializer with N=8. Inputs change #1 after
// each rising edge, and outputs are checked at the same point. Every expected
// value is a constant worked out by hand. Define SIPO_PARITY_EN for the bench
// as well as the RTL to run the parity cases.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

  localparam int N = 8;

  logic         clock;
  logic         reset;
  logic         start;
  logic         sen;
  logic         sin;
  logic         ack;
  logic [N-1:0] Q;
  logic         valid;
  logic         busy;
  logic         overrun;
  logic         perr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sipo_deserializer #(.N(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .sen     (sen),
    .sin     (sin),
    .ack     (ack),
    .Q       (Q),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun),
    .perr    (perr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Check all five outputs at once.
  task automatic chk_all(input string tag, input logic [7:0] eq, input logic ev,
                         input logic eb, input logic eo, input logic ep);
    chk({tag, ".Q"},       32'(Q),       32'(eq));
    chk({tag, ".valid"},   32'(valid),   32'(ev));
    chk({tag, ".busy"},    32'(busy),    32'(eb));
    chk({tag, ".overrun"}, 32'(overrun), 32'(eo));
    chk({tag, ".perr"},    32'(perr),    32'(ep));
  endtask

  // Send nbits of word, LSB first. Each bit is followed by a gap of
  // ((i % 3) + 1) idle cycles when gaps=1. During each gap, check that
  // Q (held at q_hold), busy and valid do not change.
  task automatic send_bits(input logic [7:0] word, input int nbits, input logic gaps,
                           input logic [7:0] q_hold);
    for (int i = 0; i < nbits; i++) begin
      sen = 1'b1;
      sin = word[i];
      tick();
      sen = 1'b0;
      if (gaps && (i < nbits - 1)) begin
        for (int g = 0; g < (i % 3) + 1; g++) begin
          sin = ~sin;
          tick();
          chk("gap.Q",     32'(Q),     32'(q_hold));
          chk("gap.busy",  32'(busy),  32'd1);
          chk("gap.valid", 32'(valid), 32'd0);
        end
      end
    end
  endtask

  // Finish a frame. In parity builds, first check that the frame is not
  // yet complete, then send the correct even-parity bit.
  task automatic finish_frame(input logic [7:0] word);
`ifdef SIPO_PARITY_EN
    chk("par.pending_valid", 32'(valid), 32'd0);
    chk("par.pending_busy",  32'(busy),  32'd1);
    sen = 1'b1;
    sin = ^word;
    tick();
    sen = 1'b0;
`else
    if (word == 8'h00) begin
      sin = 1'b0;
    end else begin
      sin = 1'b0;
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sen   = 1'b0;
    sin   = 1'b0;
    ack   = 1'b0;

    // Reset state
    tick();
    tick();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // ack while valid=0 and sen without start: both are ignored
    ack = 1'b1; sen = 1'b1; sin = 1'b1;
    tick();
    ack = 1'b0; sen = 1'b0;
    chk_all("idle_ignore", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic frame 0xA5
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("start", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(8'hA5, 7, 1'b0, 8'h00);
    chk_all("seven_bits", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(8'h01, 1, 1'b0, 8'h00);   // bit 7 of 0xA5 is 1
    finish_frame(8'hA5);
    chk_all("a5_done", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("a5_ack", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame 0xA5 with gaps between bits
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(8'hA5, 8, 1'b1, 8'hA5);
    finish_frame(8'hA5);
    chk_all("gap_done", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

    // Overrun: start while unacknowledged
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("overrun", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("overrun_hold", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    ack = 1'b1; start = 1'b1;
    tick();
    ack = 1'b0; start = 1'b0;
    chk_all("ack_start", 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);

    // Abort after 4 bits, then a full frame of 0x3C
    send_bits(8'h0F, 4, 1'b0, 8'hA5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("abort", 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    send_bits(8'h3C, 8, 1'b0, 8'hA5);
    finish_frame(8'h3C);
    chk_all("abort_3c", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Reset in the middle of a frame, then frame 0xFF
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(8'h1F, 5, 1'b0, 8'h3C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(8'hFF, 8, 1'b0, 8'h00);
    finish_frame(8'hFF);
    chk_all("ff_done", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset while valid=1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all("valid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
    // Parity: 0xA5 has four ones, so parity bit 0 is correct and 1 is an error
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(8'hA5, 8, 1'b0, 8'h00);
    chk("p0.valid_after8", 32'(valid), 32'd0);
    sen = 1'b1; sin = 1'b0;
    tick();
    sen = 1'b0;
    chk_all("p0", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    ack = 1'b1; start = 1'b1;
    tick();
    ack = 1'b0; start = 1'b0;
    send_bits(8'hA5, 8, 1'b0, 8'hA5);
    chk("p1.valid_after8", 32'(valid), 32'd0);
    sen = 1'b1; sin = 1'b1;
    tick();
    sen = 1'b0;
    chk_all("p1", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the data word width in bits (N >= 2).
REQ-002 The block SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  frame-begin strobe; the first data bit follows on a later sen cycle.
REQ-005 The block SHALL have port sen  input  1  bit-valid strobe; sin is sampled on cycles with sen=1.
REQ-006 The block SHALL have port sin  input  1  serial data, LSB first.
REQ-007 The block SHALL have port ack  input  1  consumer acknowledge of the held word.
REQ-008 The block SHALL have port Q  output  N  received parallel word, registered.
REQ-009 The block SHALL have port valid  output  1  Q holds a complete unacknowledged word.
REQ-010 The block SHALL have port busy  output  1  frame reception in progress.
REQ-011 The block SHALL have port overrun  output  1  sticky flag: start arrived while a word was unacknowledged.
REQ-012 The block SHALL have port perr  output  1  parity error for the word in Q.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, PAR (macro builds only) and DONE.
REQ-014 IDLE: start=1 SHALL move to SHIFT, clear the shift register and the bit counter; no sample is taken on the start cycle.
REQ-015 SHIFT: each sen=1 cycle SHALL shift the internal register right, with sin entering bit N-1, and increment the counter; sen=0 cycles SHALL hold all state.
REQ-016 The first received bit SHALL end in Q[0] and the Nth in Q[N-1].
REQ-017 On the Nth sample, the FSM SHALL go to DONE, or to PAR if REQ-030 applies.
REQ-018 On entry to DONE, Q SHALL load the shift register and valid SHALL rise in the clock following the final sample (latency 1 cycle).
REQ-019 Q SHALL change only on DONE entry and SHALL remain stable while valid=1.
REQ-020 DONE: ack=1 SHALL clear valid on the next edge and return to IDLE; with start=1 in the same cycle, the FSM SHALL go directly to SHIFT.
REQ-021 DONE: start=1 with ack=0 SHALL set overrun; the start SHALL be ignored and Q/valid preserved.
REQ-022 ack while valid=0 SHALL be ignored.
REQ-023 start=1 in SHIFT or PAR SHALL abort the frame, clear the counter and register, and stay in SHIFT; this is not an overrun.
REQ-024 busy SHALL be 1 exactly in SHIFT and PAR.
REQ-025 overrun SHALL be cleared only by reset.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, Q=0, valid=0, busy=0, overrun=0 and perr=0, and clear the counter and shift register.
REQ-027 Reset SHALL take priority over all inputs, including mid-frame and while valid=1; the partial frame is discarded.

Configuration
REQ-028 The macro SIPO_PARITY_EN SHALL select the parity feature.
REQ-029 Without SIPO_PARITY_EN, frames SHALL be N bits, PAR SHALL be absent, and perr SHALL be a constant 0.
REQ-030 With SIPO_PARITY_EN, after N data samples the FSM SHALL enter PAR and take one more sen=1 sample as the even-parity bit, then go to DONE.
REQ-031 With SIPO_PARITY_EN, perr SHALL load, together with Q on DONE entry, the XOR of the N data bits and the parity bit, and SHALL hold until the next DONE entry or reset.

Verification
REQ-032 The bench SHALL cover: N=8, start, then sen=1 with bits 1,0,1,0,0,1,0,1 -> valid=1 one cycle after the last bit, Q=0xA5, busy=0; ack -> valid=0 next cycle.
REQ-033 The bench SHALL cover: the same frame 0xA5 with sen=0 gaps of 1-3 cycles between bits -> Q=0xA5; Q, busy and counter unchanged during gaps.
REQ-034 The bench SHALL cover: Q=0xA5 held with ack=0, then start=1 -> overrun=1, Q=0xA5, valid=1; ack and start in the same cycle -> valid=0, busy=1, overrun remains 1.
REQ-035 The bench SHALL cover: 4 bits sent, then start again, then 8 bits of 0x3C -> Q=0x3C, not a mix of the two frames.
REQ-036 The bench SHALL cover: reset asserted after 5 bits -> all outputs 0 next cycle; the following frame 0xFF -> Q=0xFF.
REQ-037 The bench SHALL cover, with SIPO_PARITY_EN: 0xA5 with parity bit 0 -> perr=0; with parity bit 1 -> perr=1; valid in both cases after the 9th sample.
